// File: rtl/cache_fe_arbiter_pkg.sv
// cache_fe_arbiter_pkg: FSM encoding and modular index helper shared by the arbiter and its picker.
// The CACHE_ARB_FIXED_PRIO_EN build option is left undefined by default (round-robin).
package cache_fe_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int arb_wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: combinational winner search over the request vector starting at a base index,
// wrapping modulo N for non-power-of-2 counts.
module cache_arb_pick
    import cache_fe_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int M_W = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [M_W-1:0] i_base,
    output logic [M_W-1:0] o_idx,
    output logic           o_any
);

    // Scan from the far end so the last match written is the first one after the base.
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[arb_wrap_add(int'(i_base), k, N)]) o_idx = M_W'(arb_wrap_add(int'(i_base), k, N));
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/cache_fe_arbiter.sv
// cache_fe_arbiter: shares one cache front-end port between N_MASTERS requesters.
// Round-robin by default; define CACHE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module cache_fe_arbiter
    import cache_fe_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    localparam int FE_NBYTES = FE_DATA_W / 8,
    localparam int M_W = $clog2(N_MASTERS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [N_MASTERS-1:0]           i_m_valid,
    input  logic [N_MASTERS*FE_ADDR_W-1:0] i_m_addr,
    input  logic [N_MASTERS*FE_DATA_W-1:0] i_m_wdata,
    input  logic [N_MASTERS*FE_NBYTES-1:0] i_m_wstrb,
    output logic [N_MASTERS-1:0]           o_m_ready,
    output logic [FE_DATA_W-1:0]           o_m_rdata,
    output logic                           o_valid,
    output logic [FE_ADDR_W-1:0]           o_addr,
    output logic [FE_DATA_W-1:0]           o_wdata,
    output logic [FE_NBYTES-1:0]           o_wstrb,
    input  logic                           i_ready,
    input  logic [FE_DATA_W-1:0]           i_rdata,
    output logic [M_W-1:0]                 o_grant
);

    arb_state_t r_state, w_state_nxt;
    logic [M_W-1:0] r_grant, w_base, w_win;
    logic [FE_ADDR_W-1:0] r_addr;
    logic [FE_DATA_W-1:0] r_wdata;
    logic [FE_NBYTES-1:0] r_wstrb;
    logic w_any, w_load, w_done;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [M_W-1:0] r_ptr;
    assign w_base = r_ptr;
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_ptr <= '0;
        else if (w_done) r_ptr <= M_W'(arb_wrap_add(int'(r_grant), 1, N_MASTERS));
    end
`endif

    cache_arb_pick #(.N(N_MASTERS)) u_pick (
        .i_req  (i_m_valid),
        .i_base (w_base),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    always_comb begin
        w_load      = (r_state == ARB_IDLE) && w_any;
        w_done      = (r_state == ARB_BUSY) && i_ready;
        w_state_nxt = w_load ? ARB_BUSY : w_done ? ARB_IDLE : r_state;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ARB_IDLE;
        else r_state <= w_state_nxt;
    end

    // The request is frozen at grant; later changes on the master bus are ignored.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_grant <= '0;
        end else if (w_load) begin
            r_addr  <= i_m_addr[int'(w_win)*FE_ADDR_W +: FE_ADDR_W];
            r_wdata <= i_m_wdata[int'(w_win)*FE_DATA_W +: FE_DATA_W];
            r_wstrb <= i_m_wstrb[int'(w_win)*FE_NBYTES +: FE_NBYTES];
            r_grant <= w_win;
        end
    end

    assign o_m_ready = (w_done && i_reset) ? N_MASTERS'(1) << r_grant : '0;
    assign o_m_rdata = i_rdata;
    assign o_valid   = (r_state == ARB_BUSY);
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_grant   = r_grant;

endmodule

// File: tb/tb_cache_fe_arbiter.sv
// tb_cache_fe_arbiter: directed stimulus with a per-cycle reference model and literal checks, N_MASTERS=3.
module tb_cache_fe_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = DW / 8;
`ifdef CACHE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [N-1:0] m_valid = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*NB-1:0] m_wstrb = '0;
    logic [N-1:0] o_m_ready;
    logic [DW-1:0] o_m_rdata;
    logic o_valid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [NB-1:0] o_wstrb;
    logic [$clog2(N)-1:0] o_grant;

    always #5 clk = ~clk;

    cache_fe_arbiter #(.N_MASTERS(N), .FE_ADDR_W(AW), .FE_DATA_W(DW)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_m_valid (m_valid),
        .i_m_addr  (m_addr),
        .i_m_wdata (m_wdata),
        .i_m_wstrb (m_wstrb),
        .o_m_ready (o_m_ready),
        .o_m_rdata (o_m_rdata),
        .o_valid   (o_valid),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .o_wstrb   (o_wstrb),
        .i_ready   (ready),
        .i_rdata   (rdata),
        .o_grant   (o_grant)
    );

    int n_tests = 0;
    int n_fail = 0;
    bit e_busy = 1'b0;
    int e_grant = 0;
    int e_ptr = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [NB-1:0] e_wstrb = '0;
    int log_q[$];
    int vcnt = 0;
    int exp_log[5];
    logic [DW-1:0] cap_rdata = '0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [NB-1:0] cap_wstrb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        m_valid[i] = v;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*NB +: NB] = s;
    endtask

    // Cache answers ready in the first cycle it sees valid.
    task automatic auto_run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            ready = o_valid;
            rdata = 32'h5000_0000 + i;
        end
    endtask

    // Mid-cycle: compare outputs with the model, log completions, then advance the model
    // using the inputs that the coming rising edge will sample.
    task automatic model_cycle();
        logic [N-1:0] exp_rdy;
        int base;
        bit found;
        exp_rdy = (e_busy && ready && reset) ? N'(1) << e_grant : '0;
        chk("valid", o_valid, e_busy);
        chk("grant", o_grant, e_grant);
        chk("addr", o_addr, e_addr);
        chk("wdata", o_wdata, e_wdata);
        chk("wstrb", o_wstrb, e_wstrb);
        chk("m_ready", o_m_ready, exp_rdy);
        chk("m_ready_onehot", $countones(o_m_ready) <= 1, 1);
        if (exp_rdy != 0) chk("m_rdata", o_m_rdata, rdata);
        if (o_m_ready != 0) begin
            for (int k = 0; k < N; k++) if (o_m_ready[k]) log_q.push_back(k);
            cap_rdata = o_m_rdata;
            cap_addr  = o_addr;
            cap_wdata = o_wdata;
            cap_wstrb = o_wstrb;
        end
        if (o_valid) vcnt++;
        if (!reset) begin
            e_busy = 0; e_grant = 0; e_ptr = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        end else if (e_busy) begin
            if (ready) begin
                e_busy = 0;
                e_ptr = (e_grant + 1) % N;
            end
        end else begin
            base = FIXED ? 0 : e_ptr;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && m_valid[(base + k) % N]) begin
                    found = 1;
                    e_grant = (base + k) % N;
                end
            end
            if (found) begin
                e_busy  = 1;
                e_addr  = m_addr[e_grant*AW +: AW];
                e_wdata = m_wdata[e_grant*DW +: DW];
                e_wstrb = m_wstrb[e_grant*NB +: NB];
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        fork
            forever begin
                @(negedge clk);
                model_cycle();
            end
        join_none
        chk("rst_valid", o_valid, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_addr", o_addr, 0);
        reset = 1'b1;
        step();

        // Single master read, cache answers on the third busy cycle.
        vcnt = 0;
        set_req(0, 1, 32'h1000, 32'h0, 4'h0);
        step();
        step();
        step();
        ready = 1'b1;
        rdata = 32'hDEADBEEF;
        step();
        ready = 1'b0;
        m_valid[0] = 1'b0;
        step();
        chk("t1_valid_cycles", vcnt, 3);
        chk("t1_n_done", log_q.size(), 1);
        chk("t1_who", log_q.size() > 0 ? log_q[0] : -1, 0);
        chk("t1_rdata", cap_rdata, 32'hDEADBEEF);
        chk("t1_addr", cap_addr, 32'h1000);

        // Contention between masters 0 and 1, then master 0 withdraws.
        reset = 1'b0;
        step();
        reset = 1'b1;
        log_q.delete();
        set_req(0, 1, 32'h100, 32'h0, 4'h0);
        set_req(1, 1, 32'h200, 32'h0, 4'h0);
        auto_run(8);
        m_valid = 3'b010;
        auto_run(2);
        m_valid = '0;
        ready = 1'b0;
        step();
        if (FIXED) exp_log = '{0, 0, 0, 0, 1};
        else exp_log = '{0, 1, 0, 1, 1};
        chk("t2_n_done", log_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), i < log_q.size() ? log_q[i] : -1, exp_log[i]);

        // Request stability: master bus changes and valid drops after grant.
        log_q.delete();
        set_req(1, 1, 32'h2004, 32'hCAFEEFAC, 4'hF);
        step();
        set_req(1, 1, 32'h3008, 32'h12345678, 4'h1);
        step();
        m_valid[1] = 1'b0;
        step();
        ready = 1'b1;
        rdata = 32'h11112222;
        step();
        ready = 1'b0;
        step();
        chk("t3_n_done", log_q.size(), 1);
        chk("t3_who", log_q.size() > 0 ? log_q[0] : -1, 1);
        chk("t3_addr", cap_addr, 32'h2004);
        chk("t3_wdata", cap_wdata, 32'hCAFEEFAC);
        chk("t3_wstrb", cap_wstrb, 4'hF);

        // Spurious ready while idle, then wrap from master 2 back to master 0.
        log_q.delete();
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        chk("t4_spurious", log_q.size(), 0);
        set_req(0, 1, 32'h500, 32'h0, 4'h0);
        set_req(2, 1, 32'h700, 32'h0, 4'h0);
        auto_run(4);
        m_valid = '0;
        ready = 1'b0;
        step();
        chk("t4_n_done", log_q.size(), 2);
        chk("t4_first", log_q.size() > 0 ? log_q[0] : -1, FIXED ? 0 : 2);
        chk("t4_second", log_q.size() > 1 ? log_q[1] : -1, 0);

        // Reset coinciding with ready while busy.
        set_req(1, 1, 32'h4000, 32'h0, 4'h0);
        step();
        chk("t5_busy_grant", o_grant, 1);
        reset = 1'b0;
        ready = 1'b1;
        #1;
        chk("t5_m_ready", o_m_ready, 0);
        step();
        chk("t5_valid", o_valid, 0);
        chk("t5_grant", o_grant, 0);
        chk("t5_addr", o_addr, 0);
        reset = 1'b1;
        ready = 1'b0;
        m_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
